// File: rtl/alu_subsystem_md_pkg.sv
// alu_subsystem_md_pkg
//   Shared encodings for the ALU datapath stage:
//   - alu_op_e   : ALU_Op operation select
//   - srcb_e     : ALU_SrcB operand select
//   - md_state_e : state of the iterative multiply/divide unit
//   - MD_OP_*    : Md_Op encodings
package alu_subsystem_md_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOR = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B     = 2'b00,
    SRCB_PCINC = 2'b01,
    SRCB_SEL1  = 2'b10,
    SRCB_IMM   = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10
  } md_state_e;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

endpackage

// File: rtl/alu_subsystem_md_md_unit.sv
// alu_subsystem_md_md_unit
//   Iterative unsigned multiply / divide unit, one bit per clock.
//   Ports:
//     clk_i, rst_i     clock, asynchronous active-high reset
//     start_i, op_i    start request, 0 = multiply, 1 = divide
//     a_i, b_i         operands, captured on the accepting edge
//     hi_o, lo_o       mul: product high/low; div: remainder/quotient
//     done_o           one-cycle pulse, Hi/Lo were just written
//     div0_o           last accepted divide had a zero divisor
//     state_o          current FSM state (busy == state_o != MD_IDLE)
//
//   Handshake: start_i is a request that is taken on any rising edge where
//   the unit is in MD_IDLE (including the cycle done_o is high); while the
//   unit is not idle, start_i is ignored and no back-pressure is given.
//   done_o is raised for exactly one cycle on the edge that writes Hi/Lo and
//   is never high while the unit is busy.
module alu_subsystem_md_md_unit
  import alu_subsystem_md_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             done_o,
  output logic             div0_o,
  output md_state_e        state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;   // partial product high half / partial remainder
  logic [WIDTH-1:0] mq_q;    // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] b_q;     // latched multiplicand / divisor
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             div0_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mq_d;

  // One iteration of the current operation.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? b_q : {WIDTH{1'b0}})};
    div_shift = {acc_q, mq_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    acc_d     = acc_q;
    mq_d      = mq_q;
    if (state_q == MD_MUL) begin
      // {carry, acc, mq} shifted right by one; the used multiplier bit falls out.
      {acc_d, mq_d} = {mul_sum, mq_q[WIDTH-1:1]};
    end else if (state_q == MD_DIV) begin
      // Partial remainder is always below the divisor, so a trial subtract
      // that does not borrow fits in WIDTH bits.
      if (!div_diff[WIDTH]) begin
        acc_d = div_diff[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_shift[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            div0_q <= 1'b0;
            if (op_i == MD_OP_DIV && b_i == '0) begin
              // Divide by zero resolves on the accepting edge, never busy.
              lo_q   <= '1;
              hi_q   <= a_i;
              div0_q <= 1'b1;
              done_q <= 1'b1;
            end else begin
              acc_q   <= '0;
              mq_q    <= a_i;
              b_q     <= b_i;
              cnt_q   <= CW'(WIDTH);
              state_q <= (op_i == MD_OP_DIV) ? MD_DIV : MD_MUL;
            end
          end
        end
        MD_MUL, MD_DIV: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            // acc holds product-high / remainder, mq holds product-low / quotient.
            hi_q    <= acc_d;
            lo_q    <= mq_d;
            done_q  <= 1'b1;
            state_q <= MD_IDLE;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign done_o  = done_q;
  assign div0_o  = div0_q;
  assign state_o = state_q;

endmodule

// File: rtl/alu_subsystem_md.sv
// alu_subsystem_md
//   ALU datapath stage: operand muxes, combinational ALU with compare and
//   status flags, registered ALU_Out, and an iterative multiply/divide unit.
//   Ports:
//     Clock, Reset            clock, asynchronous active-high reset
//     A, B, PC_In             register operands and program counter
//     SE, ZE, SEL1            immediate variants from the extenders
//     ALU_SrcA                1 = A, 0 = PC_In
//     ALU_SrcB                00 = B, 01 = PC_INC, 10 = SEL1, 11 = SE/ZE
//     ZE_SE                   1 = SE, 0 = ZE (for ALU_SrcB = 11)
//     ALU_Op                  operation select (alu_op_e)
//     Md_Start, Md_Op         multiply/divide request, 0 = mul, 1 = div
//     ALU_Result, ALU_Out     combinational result and its registered copy
//     EQ, GR, LT              signed compare of SrcA against SrcB
//     Zero, Ovfl              result is zero; signed ADD/SUB overflow
//     Md_Busy, Md_Done        unit running; one-cycle completion pulse
//     Md_Div0                 last divide had a zero divisor
//     Hi, Lo                  multiply/divide result registers
module alu_subsystem_md
  import alu_subsystem_md_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int PC_INC = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] PC_In,
  input  logic [WIDTH-1:0] SE,
  input  logic [WIDTH-1:0] ZE,
  input  logic [WIDTH-1:0] SEL1,
  input  logic             ALU_SrcA,
  input  logic [1:0]       ALU_SrcB,
  input  logic             ZE_SE,
  input  logic [2:0]       ALU_Op,
  input  logic             Md_Start,
  input  logic             Md_Op,
  output logic [WIDTH-1:0] ALU_Result,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             EQ,
  output logic             GR,
  output logic             LT,
  output logic             Zero,
  output logic             Ovfl,
  output logic             Md_Busy,
  output logic             Md_Done,
  output logic             Md_Div0,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int               SHW      = $clog2(WIDTH);
  localparam int               MSB      = WIDTH - 1;
  localparam logic [WIDTH-1:0] PC_INC_W = WIDTH'(PC_INC);

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic [WIDTH-1:0] result;
  logic             ovfl;
  logic [WIDTH-1:0] alu_out_q;
  md_state_e        md_state;

  // Operand selection.
  always_comb begin
    src_a = ALU_SrcA ? A : PC_In;
    src_b = B;
    case (ALU_SrcB)
      SRCB_B:     src_b = B;
      SRCB_PCINC: src_b = PC_INC_W;
      SRCB_SEL1:  src_b = SEL1;
      SRCB_IMM:   src_b = ZE_SE ? SE : ZE;
      default:    src_b = B;
    endcase
  end

  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;
  assign slt  = $signed(src_a) < $signed(src_b);

  // ALU core; carries out of the top bit are discarded.
  always_comb begin
    result = '0;
    ovfl   = 1'b0;
    case (ALU_Op)
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_ADD: begin
        result = sum;
        // Like-signed operands producing a differently-signed result.
        ovfl   = (src_a[MSB] == src_b[MSB]) && (sum[MSB] != src_a[MSB]);
      end
      ALU_SUB: begin
        result = diff;
        // Unlike-signed operands where the result sign differs from SrcA.
        ovfl   = (src_a[MSB] != src_b[MSB]) && (diff[MSB] != src_a[MSB]);
      end
      ALU_XOR: result = src_a ^ src_b;
      ALU_NOR: result = ~(src_a | src_b);
      ALU_SLL: result = src_a << src_b[SHW-1:0];
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
      default: result = '0;
    endcase
  end

  assign ALU_Result = result;
  assign Ovfl       = ovfl;
  assign Zero       = (result == '0);
  assign EQ         = (src_a == src_b);
  assign LT         = slt;
  assign GR         = !slt && (src_a != src_b);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      alu_out_q <= '0;
    end else begin
      alu_out_q <= result;
    end
  end

  assign ALU_Out = alu_out_q;

  alu_subsystem_md_md_unit #(
    .WIDTH (WIDTH)
  ) u_md_unit (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .start_i (Md_Start),
    .op_i    (Md_Op),
    .a_i     (A),
    .b_i     (B),
    .hi_o    (Hi),
    .lo_o    (Lo),
    .done_o  (Md_Done),
    .div0_o  (Md_Div0),
    .state_o (md_state)
  );

  // The state register is the single source of truth for busy.
  assign Md_Busy = (md_state != MD_IDLE);

endmodule
